addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Two-port arbiter and result buffer that shares a single `cla16_addsub` instance between two requesters in the 16-bit ALU. Each requester issues add/subtract operations over a valid/ready handshake. The block grants at most one operation per cycle, round-robin by default, and returns a registered result with carry, signed-overflow and zero flags on a per-port valid/ready response channel. It sits between the ALU's issue logic and the shared adder/subtractor, and keeps a wrapping count of completed operations.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid0` / `req_valid1` in 1: request valid, per port.
- `req_ready0` / `req_ready1` out 1: request accepted this cycle (grant).
- `req_sub0` / `req_sub1` in 1: 0 = a+b; 1 = a−b.
- `req_a0` / `req_a1` in 16: operand a.
- `req_b0` / `req_b1` in 16: operand b.
- `rsp_valid0` / `rsp_valid1` out 1: result held for the port.
- `rsp_ready0` / `rsp_ready1` in 1: consumer accepts the result.
- `rsp_sum0` / `rsp_sum1` out 16: result.
- `rsp_cout0` / `rsp_cout1` out 1: adder carry-out. For subtract, 1 = no borrow.
- `rsp_ovf0` / `rsp_ovf1` out 1: two's-complement overflow.
- `rsp_zero0` / `rsp_zero1` out 1: result == 0.
- `op_count` out 16: completed handshakes since reset, wraps 0xFFFF→0x0000.

## Operation
- One shared `cla16_addsub` instance, driven combinationally by the granted port's a, b and sub. When nothing is granted, the instance is driven with zeros.
- Per port, a one-deep result buffer holds sum, cout, ovf and zero, qualified by `rsp_valid`.
- Port i is eligible when `req_valid_i && (!rsp_valid_i || rsp_ready_i)`. A drain and a refill of the same buffer may happen in the same cycle.
- `req_ready_i` is combinational from `req_valid` and `rsp_ready`. At most one `req_ready` is high per cycle.
- Arbitration:
  - Only one port eligible: that port is granted.
  - Both eligible, `RR_EN=1`: grant the port that is not `last_grant`.
  - Both eligible, `RR_EN=0`: grant port 0.
- `last_grant` updates only on a handshake. After reset, `last_grant`=1, so port 0 wins the first tie.
- On handshake (valid & ready) for port i, the next edge does the following:
  - loads buffer i with sum, cout, ovf and zero;
  - sets `rsp_valid_i`;
  - increments `op_count`.
- Otherwise, `rsp_valid_i` clears on an edge where `rsp_ready_i` is high.
- `ovf` = (a[15] == b_eff[15]) && (sum[15] != a[15]), where b_eff = b ^ {16{sub}}.
- Response data is stable while `rsp_valid_i` is high and `rsp_ready_i` is low.
- No-starvation property (`RR_EN=1`): a continuously eligible port is granted within 2 cycles.

## Timing
- Latency is 1 cycle: handshake in cycle N gives `rsp_valid` high in cycle N+1.
- Throughput is 1 operation per cycle aggregate. A single port with `rsp_ready` tied high sustains 1 operation per cycle.
- Reset values:
  - `req_ready0/1` = 0 while `rst` is high.
  - all `rsp_valid` = 0.
  - all `rsp_sum` = 0; all `rsp_cout`, `rsp_ovf`, `rsp_zero` = 0.
  - `op_count` = 0; `last_grant` = 1.
- Reset mid-operation: buffered results are discarded and no response is produced for the handshake in the reset cycle.
- Back-pressure: a full buffer with `rsp_ready` low makes that port ineligible. The other port continues to be served.
- Simultaneous events:
  - A drain and a refill of the same port in one cycle leaves `rsp_valid` high with the new data.
  - A handshake on one port and a drain on the other are independent.

## Test plan
- Single add on port 0: a=0x7FFF, b=0x0001, sub=0 → next cycle `rsp_valid0`=1, sum=0x8000, cout=0, ovf=1, zero=0; `op_count`=1.
- Subtract on port 1: a=0x1234, b=0x1234, sub=1 → sum=0x0000, cout=1, zero=1, ovf=0. Then a=0x0000, b=0x0001 → sum=0xFFFF, cout=0.
- Both ports valid for 6 cycles with `rsp_ready` high, `RR_EN=1` → grants alternate 0,1,0,1,0,1; `op_count`=6. With `RR_EN=0` → six grants to port 0, none to port 1.
- Back-pressure: hold `rsp_ready0`=0 with buffer 0 full and both ports requesting → `req_ready0`=0 and port 1 granted every cycle; `rsp_sum0` stays stable. Raise `rsp_ready0` → port 0 is granted in that same cycle.
- Assert `rst` for 1 cycle while both buffers are full and a handshake is in flight → all `rsp_valid`=0, `op_count`=0, and no stale response afterwards. The first tie after reset goes to port 0.
- Counter wrap: preload 65535 handshakes (or force `op_count`=0xFFFF), then one more handshake → `op_count`=0x0000.

Source files
------------

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-port arbiter sharing one 16-bit carry-lookahead add/sub with per-port result buffers

// 16-bit add/subtract built from four 4-bit lookahead groups with a lookahead carry across groups
module cla16_addsub (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_sub,
  output logic [15:0] o_sum,
  output logic        o_cout,
  output logic        o_ovf
);

  logic [15:0] w_b_eff;
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic [15:0] w_bc;

  // Subtraction is a + ~b + 1: the inversion happens here, the +1 enters as the carry-in
  assign w_b_eff = i_b ^ {16{i_sub}};
  assign w_g     = i_a & w_b_eff;
  assign w_p     = i_a ^ w_b_eff;

  // Group generate/propagate for each 4-bit slice
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int j = 0; j < 4; j++) begin
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      w_gp[j] = &w_p[4*j +: 4];
    end
  end

  // Second-level lookahead produces every group carry-in directly from the carry-in
  assign w_gc[0] = i_sub;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & w_gc[0]);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (&w_gp & w_gc[0]);

  // Per-bit carries inside each group, expanded from the group carry-in so nothing ripples
  always_comb begin
    w_bc = '0;
    for (int j = 0; j < 4; j++) begin
      w_bc[4*j]   = w_gc[j];
      w_bc[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
      w_bc[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                  | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
      w_bc[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                  | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                  | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
    end
  end

  assign o_sum  = w_p ^ w_bc;
  assign o_cout = w_gc[4];
  assign o_ovf  = (i_a[15] == w_b_eff[15]) && (o_sum[15] != i_a[15]);

endmodule

module addsub_arbiter #(
  parameter logic RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic        req_sub0,
  input  logic        req_sub1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_b1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [15:0] rsp_sum0,
  output logic [15:0] rsp_sum1,
  output logic        rsp_cout0,
  output logic        rsp_cout1,
  output logic        rsp_ovf0,
  output logic        rsp_ovf1,
  output logic        rsp_zero0,
  output logic        rsp_zero1,
  output logic [15:0] op_count
);

  logic        r_rsp_valid0;
  logic        r_rsp_valid1;
  logic [15:0] r_sum0;
  logic [15:0] r_sum1;
  logic        r_cout0;
  logic        r_cout1;
  logic        r_ovf0;
  logic        r_ovf1;
  logic        r_zero0;
  logic        r_zero1;
  logic [15:0] r_op_count;
  logic        r_last_grant;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_sub;
  logic [15:0] w_sum;
  logic        w_cout;
  logic        w_ovf;
  logic        w_zero;

  // A port may issue when its buffer is empty or is being drained this same cycle
  assign w_elig0 = req_valid0 && (!r_rsp_valid0 || rsp_ready0);
  assign w_elig1 = req_valid1 && (!r_rsp_valid1 || rsp_ready1);

  // Port 0 wins a tie under fixed priority, or under round-robin when port 1 went last
  assign w_gnt0 = !rst && w_elig0 && (!w_elig1 || !RR_EN || r_last_grant);
  assign w_gnt1 = !rst && w_elig1 && !w_gnt0;

  assign req_ready0 = w_gnt0;
  assign req_ready1 = w_gnt1;

  // Operand mux into the shared adder; idle cycles drive zeros to keep it quiet
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sub = 1'b0;
    if (w_gnt0) begin
      w_a   = req_a0;
      w_b   = req_b0;
      w_sub = req_sub0;
    end else if (w_gnt1) begin
      w_a   = req_a1;
      w_b   = req_b1;
      w_sub = req_sub1;
    end
  end

  cla16_addsub u_cla (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  assign w_zero = (w_sum == 16'h0000);

  // Result buffers, round-robin pointer and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_sum0       <= '0;
      r_sum1       <= '0;
      r_cout0      <= 1'b0;
      r_cout1      <= 1'b0;
      r_ovf0       <= 1'b0;
      r_ovf1       <= 1'b0;
      r_zero0      <= 1'b0;
      r_zero1      <= 1'b0;
      r_op_count   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_gnt0) begin
        r_rsp_valid0 <= 1'b1;
        r_sum0       <= w_sum;
        r_cout0      <= w_cout;
        r_ovf0       <= w_ovf;
        r_zero0      <= w_zero;
      end else if (rsp_ready0) begin
        r_rsp_valid0 <= 1'b0;
      end
      if (w_gnt1) begin
        r_rsp_valid1 <= 1'b1;
        r_sum1       <= w_sum;
        r_cout1      <= w_cout;
        r_ovf1       <= w_ovf;
        r_zero1      <= w_zero;
      end else if (rsp_ready1) begin
        r_rsp_valid1 <= 1'b0;
      end
      if (w_gnt0 || w_gnt1) begin
        r_op_count   <= r_op_count + 16'd1;
        r_last_grant <= w_gnt1;
      end
    end
  end

  assign rsp_valid0 = r_rsp_valid0;
  assign rsp_valid1 = r_rsp_valid1;
  assign rsp_sum0   = r_sum0;
  assign rsp_sum1   = r_sum1;
  assign rsp_cout0  = r_cout0;
  assign rsp_cout1  = r_cout1;
  assign rsp_ovf0   = r_ovf0;
  assign rsp_ovf1   = r_ovf1;
  assign rsp_zero0  = r_zero0;
  assign rsp_zero1  = r_zero1;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - randomized and directed bench for addsub_arbiter in round-robin and fixed-priority builds

module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rv  = '0;
  logic [1:0]  rr  = '0;
  logic [1:0]  sub = '0;
  logic [15:0] a [2];
  logic [15:0] b [2];

  // Index 0 = round-robin build, index 1 = fixed-priority build
  logic [1:0]  d_rdy  [2];
  logic [1:0]  d_rv   [2];
  logic [15:0] d_sum  [2][2];
  logic [1:0]  d_cout [2];
  logic [1:0]  d_ovf  [2];
  logic [1:0]  d_zero [2];
  logic [15:0] d_cnt  [2];

  // Reference model state
  logic        m_v    [2][2];
  logic [15:0] m_sum  [2][2];
  logic        m_cout [2][2];
  logic        m_ovf  [2][2];
  logic        m_zero [2][2];
  logic        m_last [2];
  logic [15:0] m_cnt  [2];
  logic        e_g    [2][2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req_valid0(rv[0]), .req_valid1(rv[1]),
    .req_ready0(d_rdy[0][0]), .req_ready1(d_rdy[0][1]),
    .req_sub0(sub[0]), .req_sub1(sub[1]),
    .req_a0(a[0]), .req_a1(a[1]), .req_b0(b[0]), .req_b1(b[1]),
    .rsp_valid0(d_rv[0][0]), .rsp_valid1(d_rv[0][1]),
    .rsp_ready0(rr[0]), .rsp_ready1(rr[1]),
    .rsp_sum0(d_sum[0][0]), .rsp_sum1(d_sum[0][1]),
    .rsp_cout0(d_cout[0][0]), .rsp_cout1(d_cout[0][1]),
    .rsp_ovf0(d_ovf[0][0]), .rsp_ovf1(d_ovf[0][1]),
    .rsp_zero0(d_zero[0][0]), .rsp_zero1(d_zero[0][1]),
    .op_count(d_cnt[0])
  );

  addsub_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req_valid0(rv[0]), .req_valid1(rv[1]),
    .req_ready0(d_rdy[1][0]), .req_ready1(d_rdy[1][1]),
    .req_sub0(sub[0]), .req_sub1(sub[1]),
    .req_a0(a[0]), .req_a1(a[1]), .req_b0(b[0]), .req_b1(b[1]),
    .rsp_valid0(d_rv[1][0]), .rsp_valid1(d_rv[1][1]),
    .rsp_ready0(rr[0]), .rsp_ready1(rr[1]),
    .rsp_sum0(d_sum[1][0]), .rsp_sum1(d_sum[1][1]),
    .rsp_cout0(d_cout[1][0]), .rsp_cout1(d_cout[1][1]),
    .rsp_ovf0(d_ovf[1][0]), .rsp_ovf1(d_ovf[1][1]),
    .rsp_zero0(d_zero[1][0]), .rsp_zero1(d_zero[1][1]),
    .op_count(d_cnt[1])
  );

  // Arithmetic reference using integer math rather than bit-level carries
  function automatic void calc(input logic [15:0] x, input logic [15:0] y, input logic s,
                               output logic [15:0] r, output logic c, output logic o, output logic z);
    int sx, sy, sr;
    int unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    if (s) begin
      sr = sx - sy;
      r  = x - y;
      c  = (ux >= uy);
    end else begin
      sr = sx + sy;
      r  = x + y;
      c  = (ux + uy) > 32'd65535;
    end
    o = (sr > 32767) || (sr < -32768);
    z = (r == 16'h0000);
  endfunction

  // Expected grants for the current inputs, from the arbitration rules
  task automatic predict();
    logic el0, el1;
    for (int k = 0; k < 2; k++) begin
      el0 = rv[0] && (!m_v[k][0] || rr[0]);
      el1 = rv[1] && (!m_v[k][1] || rr[1]);
      e_g[k][0] = 1'b0;
      e_g[k][1] = 1'b0;
      if (!rst) begin
        if (el0 && el1) begin
          if (k == 0 && !m_last[k]) e_g[k][1] = 1'b1;
          else                      e_g[k][0] = 1'b1;
        end else if (el0) begin
          e_g[k][0] = 1'b1;
        end else if (el1) begin
          e_g[k][1] = 1'b1;
        end
      end
    end
  endtask

  // Advance one clock and move the model to its post-edge state
  task automatic tick();
    logic [15:0] r;
    logic c, o, z;
    predict();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_v[k][i] = 1'b0; m_sum[k][i] = '0; m_cout[k][i] = 1'b0;
          m_ovf[k][i] = 1'b0; m_zero[k][i] = 1'b0;
        end
        m_last[k] = 1'b1;
        m_cnt[k]  = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (e_g[k][i]) begin
            calc(a[i], b[i], sub[i], r, c, o, z);
            m_v[k][i] = 1'b1; m_sum[k][i] = r; m_cout[k][i] = c;
            m_ovf[k][i] = o; m_zero[k][i] = z;
          end else if (rr[i]) begin
            m_v[k][i] = 1'b0;
          end
        end
        if (e_g[k][0] || e_g[k][1]) begin
          m_cnt[k]  = m_cnt[k] + 16'd1;
          m_last[k] = e_g[k][1];
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; rr = 2'b11;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 2'b11; rr = 2'b11;
    a[0] = 16'($urandom); b[0] = 16'($urandom); a[1] = 16'($urandom); b[1] = 16'($urandom);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_rdy[k] !== 2'b00) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 00", k, d_rdy[k]); end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_rv[k], d_cout[k], d_ovf[k], d_zero[k]} !== 8'h00) begin
        errors++; $display("FAIL reset_flags[%0d]: got %h expected 00", k, {d_rv[k], d_cout[k], d_ovf[k], d_zero[k]});
      end
      checks++;
      if (d_sum[k][0] !== 16'h0 || d_sum[k][1] !== 16'h0) begin
        errors++; $display("FAIL reset_sum[%0d]: got %h/%h expected 0000/0000", k, d_sum[k][0], d_sum[k][1]);
      end
      checks++;
      if (d_cnt[k] !== 16'h0) begin errors++; $display("FAIL reset_count[%0d]: got %h expected 0000", k, d_cnt[k]); end
    end
    rst = 1'b0; rv = '0;
  endtask

  task automatic test_single_add();
    rv = 2'b01; rr = 2'b11; a[0] = 16'h7FFF; b[0] = 16'h0001; sub[0] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_rdy[k] !== 2'b01) begin errors++; $display("FAIL add_ready[%0d]: got %b expected 01", k, d_rdy[k]); end
    end
    tick();
    rv = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_rv[k][0], d_sum[k][0], d_cout[k][0], d_ovf[k][0], d_zero[k][0], d_cnt[k]} !== {1'b1, 16'h8000, 3'b010, 16'd1}) begin
        errors++;
        $display("FAIL add_result[%0d]: got v=%b sum=%h c=%b o=%b z=%b cnt=%0d expected v=1 sum=8000 c=0 o=1 z=0 cnt=1",
                 k, d_rv[k][0], d_sum[k][0], d_cout[k][0], d_ovf[k][0], d_zero[k][0], d_cnt[k]);
      end
    end
  endtask

  task automatic test_subtract();
    rv = 2'b10; rr = 2'b11; a[1] = 16'h1234; b[1] = 16'h1234; sub[1] = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_rv[k][1], d_sum[k][1], d_cout[k][1], d_ovf[k][1], d_zero[k][1]} !== {1'b1, 16'h0000, 3'b101}) begin
        errors++;
        $display("FAIL sub_equal[%0d]: got v=%b sum=%h c=%b o=%b z=%b expected v=1 sum=0000 c=1 o=0 z=1",
                 k, d_rv[k][1], d_sum[k][1], d_cout[k][1], d_ovf[k][1], d_zero[k][1]);
      end
    end
    a[1] = 16'h0000; b[1] = 16'h0001;
    tick();
    rv = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_sum[k][1], d_cout[k][1], d_zero[k][1]} !== {16'hFFFF, 2'b00}) begin
        errors++; $display("FAIL sub_borrow[%0d]: got sum=%h c=%b z=%b expected sum=ffff c=0 z=0",
                           k, d_sum[k][1], d_cout[k][1], d_zero[k][1]);
      end
      checks++;
      if (d_cnt[k] !== 16'd3) begin errors++; $display("FAIL sub_count[%0d]: got %0d expected 3", k, d_cnt[k]); end
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    rv = 2'b11; rr = 2'b11;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 2; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); sub[i] = 1'($urandom); end
      #1;
      checks++;
      if (d_rdy[0] !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_grant cycle %0d: got %b expected %b", c, d_rdy[0], (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      checks++;
      if (d_rdy[1] !== 2'b01) begin errors++; $display("FAIL fp_grant cycle %0d: got %b expected 01", c, d_rdy[1]); end
      tick();
    end
    rv = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_cnt[k] !== 16'd6) begin errors++; $display("FAIL tie_count[%0d]: got %0d expected 6", k, d_cnt[k]); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    do_reset();
    rv = 2'b01; rr = 2'b11; a[0] = 16'($urandom); b[0] = 16'($urandom); sub[0] = 1'b1;
    tick();
    held = m_sum[0][0];
    checks++;
    if (d_sum[0][0] !== held) begin errors++; $display("FAIL bp_load: got %h expected %h", d_sum[0][0], held); end
    rv = 2'b11; rr = 2'b10;
    for (int c = 0; c < 4; c++) begin
      a[0] = 16'($urandom); a[1] = 16'($urandom); b[1] = 16'($urandom);
      #1;
      checks++;
      if (d_rdy[0] !== 2'b10) begin errors++; $display("FAIL bp_grant cycle %0d: got %b expected 10", c, d_rdy[0]); end
      tick();
      checks++;
      if (d_rv[0][0] !== 1'b1 || d_sum[0][0] !== held) begin
        errors++; $display("FAIL bp_hold cycle %0d: got v=%b sum=%h expected v=1 sum=%h", c, d_rv[0][0], d_sum[0][0], held);
      end
    end
    rr = 2'b11;
    #1;
    checks++;
    if (d_rdy[0] !== 2'b01) begin errors++; $display("FAIL bp_release: got %b expected 01", d_rdy[0]); end
    tick();
    rv = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rv = 2'b11; rr = 2'b00;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_rv[k] !== 2'b11) begin errors++; $display("FAIL mid_full[%0d]: got %b expected 11", k, d_rv[k]); end
    end
    rr = 2'b01; rst = 1'b1;
    #1;
    checks++;
    if (d_rdy[0] !== 2'b00 || d_rdy[1] !== 2'b00) begin
      errors++; $display("FAIL mid_ready: got %b/%b expected 00/00", d_rdy[0], d_rdy[1]);
    end
    tick();
    rst = 1'b0; rv = '0; rr = 2'b11;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_rv[k] !== 2'b00 || d_cnt[k] !== 16'h0) begin
        errors++; $display("FAIL mid_cleared[%0d]: got v=%b cnt=%0d expected v=00 cnt=0", k, d_rv[k], d_cnt[k]);
      end
    end
    tick();
    checks++;
    if (d_rv[0] !== 2'b00 || d_rv[1] !== 2'b00) begin
      errors++; $display("FAIL mid_stale: got %b/%b expected 00/00", d_rv[0], d_rv[1]);
    end
    rv = 2'b11;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_rdy[k] !== 2'b01) begin errors++; $display("FAIL mid_first_tie[%0d]: got %b expected 01", k, d_rdy[k]); end
    end
    tick();
    rv = '0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] edge_vals [4];
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'h7FFF; edge_vals[2] = 16'h8000; edge_vals[3] = 16'hFFFF;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rv = 2'($urandom); rr = 2'($urandom); sub = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
        b[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
      end
      predict();
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (d_rdy[k] !== {e_g[k][1], e_g[k][0]}) begin
          errors++; $display("FAIL rand_ready[%0d] cycle %0d: got %b expected %b", k, c, d_rdy[k], {e_g[k][1], e_g[k][0]});
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (d_rv[k][i] !== m_v[k][i]) begin
            errors++; $display("FAIL rand_valid[%0d][%0d] cycle %0d: got %b expected %b", k, i, c, d_rv[k][i], m_v[k][i]);
          end else if (m_v[k][i] && {d_sum[k][i], d_cout[k][i], d_ovf[k][i], d_zero[k][i]}
                                    !== {m_sum[k][i], m_cout[k][i], m_ovf[k][i], m_zero[k][i]}) begin
            errors++;
            $display("FAIL rand_data[%0d][%0d] cycle %0d: got sum=%h c=%b o=%b z=%b expected sum=%h c=%b o=%b z=%b",
                     k, i, c, d_sum[k][i], d_cout[k][i], d_ovf[k][i], d_zero[k][i],
                     m_sum[k][i], m_cout[k][i], m_ovf[k][i], m_zero[k][i]);
          end
        end
        checks++;
        if (d_cnt[k] !== m_cnt[k]) begin
          errors++; $display("FAIL rand_count[%0d] cycle %0d: got %0d expected %0d", k, c, d_cnt[k], m_cnt[k]);
        end
      end
    end
    rv = '0; rr = 2'b11;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    rv = 2'b01; rr = 2'b11; a[0] = 16'h0001; b[0] = 16'h0002; sub[0] = 1'b0;
    for (int c = 0; c < 65535; c++) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_cnt[k] !== 16'hFFFF) begin errors++; $display("FAIL wrap_max[%0d]: got %h expected ffff", k, d_cnt[k]); end
    end
    tick();
    rv = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_cnt[k] !== 16'h0000) begin errors++; $display("FAIL wrap_zero[%0d]: got %h expected 0000", k, d_cnt[k]); end
    end
  endtask

  initial begin
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1'b1; m_cnt[k] = '0;
      for (int i = 0; i < 2; i++) begin
        m_v[k][i] = 1'b0; m_sum[k][i] = '0; m_cout[k][i] = 1'b0;
        m_ovf[k][i] = 1'b0; m_zero[k][i] = 1'b0; e_g[k][i] = 1'b0;
      end
    end
    test_reset();
    test_single_add();
    test_subtract();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
